// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD picture constants, colours and loader state type
package lcd_pkg;

    localparam int PIC_SIZE  = 400;
    localparam int PIX_TOTAL = PIC_SIZE * PIC_SIZE;

    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] GREEN  = 24'h00FF00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ldr_state_e;

endpackage

// File: rtl/lcd_pix_pack.sv
// rtl/lcd_pix_pack.sv - packs R,G,B byte triples into one pixel, pulses on the B byte
module lcd_pix_pack #(
    parameter int PIX_W = 24
) (
    input  logic             clk_in,
    input  logic             sys_rst_n,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic [7:0]       byte_i,
    output logic             pix_valid_o,
    output logic [PIX_W-1:0] pix_o
);

    logic [1:0]       phase_q;
    logic [1:0]       phase_d;
    logic [PIX_W-9:0] hi_q;
    logic [PIX_W-9:0] hi_d;

    // Next phase and R/G capture; clear wins over an accept in the same cycle
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clr_i) begin
            phase_d = 2'd0;
            hi_d    = '0;
        end else if (acc_i) begin
            case (phase_q)
                2'd0: begin
                    hi_d[PIX_W-9 -: 8] = byte_i;
                    phase_d            = 2'd1;
                end
                2'd1: begin
                    hi_d[7:0] = byte_i;
                    phase_d   = 2'd2;
                end
                default: phase_d = 2'd0;
            endcase
        end
    end

    // Phase counter and upper-bytes assembly register
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q <= 2'd0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    // The B byte completes the pixel combinationally so the caller can register it
    assign pix_valid_o = acc_i && !clr_i && (phase_q == 2'd2);
    assign pix_o       = {hi_q, byte_i};

endmodule

// File: rtl/lcd_pic_loader.sv
// rtl/lcd_pic_loader.sv - byte stream to picture RAM loader (optional LCD_PIC_LOADER_CKSUM_EN)
module lcd_pic_loader #(
    parameter int PIC_SIZE = lcd_pkg::PIC_SIZE,
    parameter int ADDR_W   = 18,
    parameter int PIX_W    = 24
) (
    input  logic              clk_in,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
`ifdef LCD_PIC_LOADER_CKSUM_EN
    ,
    output logic [15:0]       cksum
`endif
);

    import lcd_pkg::*;

    localparam int                PIX_TOT   = PIC_SIZE * PIC_SIZE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOT - 1);

    ldr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic              done_q;

    logic              load_w;
    logic              acc_w;
    logic              pix_valid_w;
    logic [PIX_W-1:0]  pix_w;

    assign load_w = (state_q == LOAD);
    // A byte arriving together with start belongs to the abandoned load
    assign acc_w  = s_valid && load_w && !start;

    lcd_pix_pack #(
        .PIX_W(PIX_W)
    ) u_pack (
        .clk_in     (clk_in),
        .sys_rst_n  (sys_rst_n),
        .clr_i      (start),
        .acc_i      (acc_w),
        .byte_i     (s_data),
        .pix_valid_o(pix_valid_w),
        .pix_o      (pix_w)
    );

    // Loader FSM: pixel counter, one-cycle RAM write strobe and completion flag
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (start) begin
                state_q <= LOAD;
                cnt_q   <= '0;
                done_q  <= 1'b0;
            end else if (pix_valid_w) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cnt_q;
                wr_data_q <= pix_w;
                if (cnt_q == LAST_ADDR) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign s_ready = load_w;
    assign busy    = load_w;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

`ifdef LCD_PIC_LOADER_CKSUM_EN
    logic [15:0] cksum_q;

    // Running 16-bit sum of accepted bytes, restarted by start
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cksum_q <= 16'd0;
        end else if (start) begin
            cksum_q <= 16'd0;
        end else if (acc_w) begin
            cksum_q <= cksum_q + {8'd0, s_data};
        end
    end

    assign cksum = cksum_q;
`endif

endmodule
